// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame defaults and the
// baud-tick divider constants used by the transmitter and baud generator.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  localparam int CLK_HZ   = 100_000_000;
  localparam int BAUD     = 9600;
  localparam int TICK_DIV = CLK_HZ / (BAUD * DEF_OVERSAMPLE);
  localparam int TICK_DIV_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle: recovered byte, strobes and busy flag.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output data, valid, frame_err, busy);
  modport slave  (input  data, valid, frame_err, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Synchronizer for the serial line plus a tick-qualified falling-edge detector.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_rxd,
  input  logic i_track,
  output logic rxd_s,
  output logic fall_det
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_high_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
      logic stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = i_rxd;
      end else begin : g_chain
        assign stage_in = sync_reg[gi-1];
      end
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) sync_reg[gi] <= 1'b1;
        else          sync_reg[gi] <= stage_in;
      end
    end
  endgenerate

  assign rxd_s = sync_reg[STAGES-1];

  // Cleared in reset so a line held low through reset never looks like a start.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)              prev_high_reg <= 1'b0;
    else if (i_tick && i_track) prev_high_reg <= rxd_s;
  end

  assign fall_det = i_tick & prev_high_reg & ~rxd_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling, mid-bit sampling and
// framing-error detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rxd,
  uart_rx_if.master rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] sh_reg, sh_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 err_reg, err_next;
  logic                 track;
  logic                 rxd_s;
  logic                 fall_det;
  logic [DATA_BITS:0]   sh_wide;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_tick   (i_tick),
    .i_rxd    (i_rxd),
    .i_track  (track),
    .rxd_s    (rxd_s),
    .fall_det (fall_det)
  );

  assign sh_wide = {rxd_s, sh_reg};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sh_reg       <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      sh_reg       <= sh_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    sh_next       = sh_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    track         = 1'b0;
    case (state_reg)
      IDLE: begin
        track = 1'b1;
        // The detection tick is the first tick of the start bit, so counting
        // resumes at 1 and the mid-bit point lands OVERSAMPLE/2-1 ticks later.
        if (fall_det) begin
          tick_cnt_next = TW'(1);
          state_next    = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt_reg == HALF) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = rxd_s ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt_reg == LAST) begin
            sh_next       = sh_wide[DATA_BITS:1];
            tick_cnt_next = '0;
            bit_cnt_next  = bit_cnt_reg + BW'(1);
            if (bit_cnt_reg == LAST_BIT) state_next = STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick_cnt_reg == LAST) track = 1'b1;
        if (i_tick) begin
          if (tick_cnt_reg == LAST) begin
            if (rxd_s) begin
              data_next  = sh_reg;
              valid_next = 1'b1;
            end else begin
              err_next   = 1'b1;
            end
            tick_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx.data      = data_reg;
  assign rx.valid     = valid_reg;
  assign rx.frame_err = err_reg;
  assign rx.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table plus hand-written glitch, break and reset
// sequences, checked against a scoreboard of expected receive events.
module tb_uart_rx;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;
  logic i_tick  = 1'b0;
  logic i_rxd   = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) rx ();

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tick  (i_tick),
    .i_rxd   (i_rxd),
    .rx      (rx)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tick_period = 1;
  int tick_phase  = 0;
  always @(negedge i_clk) begin
    tick_phase = (tick_phase + 1) % tick_period;
    i_tick     = (tick_phase == 0);
  end

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_lvl;
    logic       chk_lat;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   last_valid_cyc = 0;
  logic valid_d = 1'b0;
  logic err_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every strobe must match the oldest outstanding expected event.
  always @(negedge i_clk) begin
    exp_t e;
    if (rx.valid || rx.frame_err) begin
      check("pulse_exclusive", 32'(rx.valid & rx.frame_err), 0);
      check("pulse_width", 32'((rx.valid & valid_d) | (rx.frame_err & err_d)), 0);
      if (rx.valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (rx.frame_err) n_err++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h with nothing expected (cycle %0d)",
                 rx.valid, rx.frame_err, rx.data, cyc);
      end else begin
        e = sb.pop_front();
        $display("rx event: valid=%0b frame_err=%0b data=0x%02h expected err=%0b data=0x%02h (cycle %0d)",
                 rx.valid, rx.frame_err, rx.data, e.is_err, e.data, cyc);
        check("pulse_kind", 32'(rx.frame_err), 32'(e.is_err));
        check("rx_data", 32'(rx.data), 32'(e.data));
      end
    end
    valid_d = rx.valid;
    err_d   = rx.frame_err;
  end

  task automatic hold(input logic lvl, input int nticks);
    i_rxd = lvl;
    repeat (nticks * tick_period) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, output int t_start);
    t_start = cyc;
    hold(1'b0, 16);
    for (int b = 0; b < 8; b++) hold(d[b], 16);
    hold(stop_lvl, 16);
  endtask

  vec_t       vecs[4];
  logic [7:0] last_good;
  int         t0;
  int         nv0;
  int         ne0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0};
    last_good = 8'h00;

    // Reset with idle line, then a long idle period.
    i_reset = 1'b0;
    i_rxd   = 1'b1;
    repeat (5) @(negedge i_clk);
    check("reset_data", 32'(rx.data), 0);
    check("reset_valid", 32'(rx.valid), 0);
    check("reset_err", 32'(rx.frame_err), 0);
    check("reset_busy", 32'(rx.busy), 0);
    i_reset = 1'b1;
    hold(1'b1, 1000);
    check("idle_busy", 32'(rx.busy), 0);
    check("idle_no_valid", 32'(n_valid), 0);
    check("idle_no_err", 32'(n_err), 0);

    // Back-to-back frames from the table; the first also checks latency.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].stop_lvl) sb.push_back('{1'b0, vecs[i].data});
      else                  sb.push_back('{1'b1, last_good});
      send_frame(vecs[i].data, vecs[i].stop_lvl, t0);
      if (vecs[i].stop_lvl) last_good = vecs[i].data;
      if (vecs[i].chk_lat) check("valid_latency", 32'(last_valid_cyc - t0), 154);
    end
    check("table_valid_count", 32'(n_valid), 4);

    // Glitch: short low pulse must be rejected as a false start.
    nv0 = n_valid;
    ne0 = n_err;
    hold(1'b0, 4);
    check("glitch_busy_high", 32'(rx.busy), 1);
    hold(1'b1, 20);
    check("glitch_busy_low", 32'(rx.busy), 0);
    check("glitch_no_pulse", 32'((n_valid - nv0) + (n_err - ne0)), 0);

    // Framing error followed by a break: exactly one error, data held.
    ne0 = n_err;
    sb.push_back('{1'b1, last_good});
    send_frame(8'h55, 1'b0, t0);
    hold(1'b0, 480);
    check("break_one_err", 32'(n_err - ne0), 1);
    check("break_data_held", 32'(rx.data), 32'(last_good));
    hold(1'b1, 20);
    nv0 = n_valid;
    sb.push_back('{1'b0, 8'h81});
    send_frame(8'h81, 1'b1, t0);
    last_good = 8'h81;
    check("after_break_valid", 32'(n_valid - nv0), 1);

    // Slow tick with reset during data bit 3 of 0xC3.
    tick_period = 4;
    hold(1'b1, 20);
    nv0 = n_valid;
    ne0 = n_err;
    hold(1'b0, 16);
    for (int b = 0; b < 3; b++) hold(vecs[0].data[b] ^ 1'b0 ? 1'b1 : 1'b0, 0);
    hold(1'b1, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b0, 6);
    i_reset = 1'b0;
    #1;
    check("midreset_data", 32'(rx.data), 0);
    check("midreset_busy", 32'(rx.busy), 0);
    check("midreset_strobes", 32'(rx.valid | rx.frame_err), 0);
    repeat (3) @(negedge i_clk);
    i_rxd   = 1'b1;
    i_reset = 1'b1;
    hold(1'b1, 20);
    check("midreset_no_pulse", 32'((n_valid - nv0) + (n_err - ne0)), 0);
    sb.push_back('{1'b0, 8'h12});
    send_frame(8'h12, 1'b1, t0);
    check("slow_rx_data", 32'(rx.data), 32'h12);
    check("slow_valid_count", 32'(n_valid - nv0), 1);

    for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge i_clk);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
